// File: rtl/force_run_reducer.sv
// force_run_reducer: drains a show-ahead 64-bit FIFO of partial force
// contributions {id, fx, fy, fz}, sums consecutive entries of the same id
// and emits one reduced record per run over a valid/ready handshake.
//
// Optional feature macro: FORCE_REDUCE_SAT_EN
//   defined   -> accumulator adds saturate to the signed ACC_W range
//   undefined -> accumulator adds wrap modulo 2^ACC_W
//
// Handshake: a record is transferred on a rising clk edge where
// out_valid && out_ready; while out_valid && !out_ready every out_* signal
// holds, and out_valid only drops after a transfer.
module force_run_reducer #(
  parameter int ID_W   = 16,
  parameter int COMP_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       fifo_out,
  input  logic              fifo_empty,
  output logic              fifo_consume,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [ACC_W-1:0]  out_fx,
  output logic [ACC_W-1:0]  out_fy,
  output logic [ACC_W-1:0]  out_fz,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_RUN = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ACC_W-1:0]   fx_q, fx_d, fy_q, fy_d, fz_q, fz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               consume;
  logic               load;
  logic               accum;

  // Head entry fields of the show-ahead FIFO.
  logic [ID_W-1:0]    head_id;
  logic [COMP_W-1:0]  head_fx, head_fy, head_fz;
  assign head_id = fifo_out[63:64-ID_W];
  assign head_fx = fifo_out[3*COMP_W-1:2*COMP_W];
  assign head_fy = fifo_out[2*COMP_W-1:COMP_W];
  assign head_fz = fifo_out[COMP_W-1:0];

  function automatic logic [ACC_W-1:0] sext(input logic [COMP_W-1:0] c);
    return ACC_W'($signed(c));
  endfunction

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
`ifdef FORCE_REDUCE_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree only on signed overflow; clamp toward the sign.
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Next-state, pop decision and accumulator datapath.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    fz_d    = fz_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    load    = 1'b0;
    accum   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          consume = 1'b1;
          load    = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!fifo_empty && head_id == id_q && cnt_q != MAX_RUN) begin
          consume = 1'b1;
          accum   = 1'b1;
        end else if (!fifo_empty || cnt_q == MAX_RUN || flush) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            // Back-to-back restart: the head opens the next run immediately.
            consume = 1'b1;
            load    = 1'b1;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      id_d  = head_id;
      fx_d  = sext(head_fx);
      fy_d  = sext(head_fy);
      fz_d  = sext(head_fz);
      cnt_d = CNT_W'(1);
    end else if (accum) begin
      fx_d  = acc_add(fx_q, sext(head_fx));
      fy_d  = acc_add(fy_q, sext(head_fy));
      fz_d  = acc_add(fz_q, sext(head_fz));
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and accumulator registers; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fz_q    <= fz_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accumulators are frozen in EMIT, so they serve directly as the record.
  assign fifo_consume = consume && !rst;
  assign out_valid    = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
  assign out_id       = id_q;
  assign out_fx       = fx_q;
  assign out_fy       = fy_q;
  assign out_fz       = fz_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_force_run_reducer.sv
// Directed bench for force_run_reducer, built with CNT_W = 3 and ACC_W = 17
// so the run-length cap and accumulator overflow are reachable quickly.
module tb_force_run_reducer;

  localparam int ID_W   = 16;
  localparam int COMP_W = 16;
  localparam int ACC_W  = 17;
  localparam int CNT_W  = 3;
  localparam int REC_W  = ID_W + 3 * ACC_W + CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63:0]       fifo_out;
  logic              fifo_empty;
  logic              fifo_consume;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ID_W-1:0]   out_id;
  logic [ACC_W-1:0]  out_fx, out_fy, out_fz;
  logic [CNT_W-1:0]  out_count;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  logic [REC_W-1:0] exp_q[$];

  // Upstream show-ahead FIFO model.
  logic [63:0] mem [0:255];
  int rd = 0;
  int wr = 0;
  assign fifo_out   = mem[rd[7:0]];
  assign fifo_empty = (rd == wr);

  always @(posedge clk) if (fifo_consume) rd <= rd + 1;

  // Clock.
  always #5 clk = ~clk;

  force_run_reducer #(
    .ID_W(ID_W), .COMP_W(COMP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_out(fifo_out), .fifo_empty(fifo_empty), .fifo_consume(fifo_consume),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_fx(out_fx), .out_fy(out_fy), .out_fz(out_fz),
    .out_count(out_count), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [63:0] entry(input int id, input int fx, input int fy, input int fz);
    return {16'(id), 16'(fx), 16'(fy), 16'(fz)};
  endfunction

  function automatic logic [REC_W-1:0] rec(input int id, input int fx, input int fy,
                                           input int fz, input int cnt);
    return {ID_W'(id), ACC_W'(fx), ACC_W'(fy), ACC_W'(fz), CNT_W'(cnt)};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] e);
    mem[wr[7:0]] = e;
    wr = wr + 1;
  endtask

  // One cycle: scoreboard/monitor at negedge, then return just after posedge.
  task automatic step();
    logic [REC_W-1:0] obs;
    @(negedge clk);
    if (!rst && out_valid) begin
      chk("unexpected_record", 80'(exp_q.size() != 0), 80'(1));
      if (exp_q.size() != 0) begin
        obs = {out_id, out_fx, out_fy, out_fz, out_count};
        chk("record", 80'(obs), 80'(exp_q[0]));
        if (out_ready) exp_q.pop_front();
      end
      if (!out_ready)
        chk("no_pop_while_blocked", 80'(fifo_consume), 80'(0));
      else if (!fifo_empty)
        chk("b2b_restart_pop", 80'(fifo_consume), 80'(1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && rd != wr; i++) step();
    chk("fifo_drained", 80'(rd == wr), 80'(1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk("records_drained", 80'(exp_q.size()), 80'(0));
    step();
    chk("idle_after_run", 80'(busy), 80'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state, with a non-empty FIFO to prove the pop is suppressed.
    push(entry(5, 1, -2, 3));
    push(entry(5, 1, -2, 3));
    push(entry(5, 1, -2, 3));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_consume", 80'(fifo_consume), 80'(0));
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_record", 80'({out_id, out_fx, out_fy, out_fz, out_count}), 80'(0));
    @(posedge clk); #1;

    // Test 1: single-id run closed by flush.
    exp_q.push_back(rec(5, 3, -6, 9, 3));
    rst = 1'b0;
    wait_empty(20);
    do_flush();
    drain(20);

    // Test 2: id change with downstream always ready.
    exp_q.push_back(rec(7, 5, -1, 0, 2));
    exp_q.push_back(rec(9, 4, 100, -100, 1));
    push(entry(7, 2, -3, 7));
    push(entry(7, 3, 2, -7));
    push(entry(9, 4, 100, -100));
    wait_empty(20);
    do_flush();
    drain(20);

    // Test 3: backpressure for 10 cycles in EMIT.
    out_ready = 1'b0;
    exp_q.push_back(rec(3, 30, -20, 2, 2));
    exp_q.push_back(rec(4, -8, 8, 1, 1));
    push(entry(3, 10, -10, 1));
    push(entry(3, 20, -10, 1));
    push(entry(4, -8, 8, 1));
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk("emit_reached", 80'(out_valid), 80'(1));
    for (int i = 0; i < 10; i++) step();
    chk("head_still_queued", 80'(wr - rd), 80'(1));
    out_ready = 1'b1;
    step();
    chk("handshake_popped_head", 80'(rd == wr), 80'(1));
    wait_empty(20);
    do_flush();
    drain(20);

    // Test 4: run-length cap of 7 splits a 9-entry run.
    exp_q.push_back(rec(1, 7, 0, 0, 7));
    exp_q.push_back(rec(1, 2, 0, 0, 2));
    for (int i = 0; i < 9; i++) push(entry(1, 1, 0, 0));
    wait_empty(30);
    do_flush();
    drain(20);

    // Test 5: accumulator overflow, positive on fx and negative on fy.
`ifdef FORCE_REDUCE_SAT_EN
    exp_q.push_back(rec(11, 65535, -65536, 0, 4));
`else
    exp_q.push_back(rec(11, 131068, 0, 0, 4));
`endif
    for (int i = 0; i < 4; i++) push(entry(11, 32767, -32768, 0));
    wait_empty(20);
    do_flush();
    drain(20);

    // Test 6: reset in the middle of an open run of count 4.
    for (int i = 0; i < 4; i++) push(entry(6, 1, 1, 1));
    wait_empty(20);
    step();
    chk("mid_run_busy", 80'(busy), 80'(1));
    rst = 1'b1;
    push(entry(2, 5, -5, 6));
    #1;
    chk("async_rst_busy", 80'(busy), 80'(0));
    chk("async_rst_valid", 80'(out_valid), 80'(0));
    chk("async_rst_consume", 80'(fifo_consume), 80'(0));
    chk("async_rst_record", 80'({out_id, out_fx, out_fy, out_fz, out_count}), 80'(0));
    step();
    exp_q.push_back(rec(2, 5, -5, 6, 1));
    rst = 1'b0;
    wait_empty(20);
    do_flush();
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
